// File: rtl/fifo_pkt_writer.sv
// Packet framer for the write port of the dual-clock FIFO: header (seq), data words, trailer (count).
// Define FIFO_WR_CSUM_EN to append an XOR checksum word after the trailer.
module fifo_pkt_writer #(
    parameter int DW      = 8,
    parameter int MAX_LEN = 16,
    parameter int CW      = 5
) (
    input  logic          wr_clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    output logic [DW-1:0] fifo_din,
    output logic          fifo_we,
    input  logic          fifo_full,
    input  logic          fifo_full_n,
    output logic          busy,
    output logic          trunc,
    output logic [DW-1:0] seq
);

    // state | meaning
    // IDLE  | waiting for a source word and room for a whole packet
    // HDR   | writing the sequence-number header
    // DATA  | forwarding source words
    // TRL   | writing the word-count trailer
    // CSUM  | writing the XOR checksum (checksum builds only)
    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
`ifdef FIFO_WR_CSUM_EN
        CSUM,
`endif
        TRL
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] seq_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic          trunc_nxt;
`ifdef FIFO_WR_CSUM_EN
    logic [DW-1:0] csum, csum_nxt;
`endif

    assign cnt_inc = cnt + CW'(1);
    assign busy    = (state != IDLE);

    always_ff @(posedge wr_clk) begin
        if (!rst || clr) begin
            state <= IDLE;
            seq   <= '0;
            cnt   <= '0;
            trunc <= 1'b0;
`ifdef FIFO_WR_CSUM_EN
            csum  <= '0;
`endif
        end else begin
            state <= state_nxt;
            seq   <= seq_nxt;
            cnt   <= cnt_nxt;
            trunc <= trunc_nxt;
`ifdef FIFO_WR_CSUM_EN
            csum  <= csum_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        seq_nxt   = seq;
        cnt_nxt   = cnt;
        trunc_nxt = 1'b0;
        fifo_we   = 1'b0;
        fifo_din  = '0;
        s_ready   = 1'b0;
`ifdef FIFO_WR_CSUM_EN
        csum_nxt  = csum;
`endif
        case (state)
            IDLE: begin
                if (s_valid && !fifo_full_n)
                    state_nxt = HDR;
            end
            HDR: begin
                if (!fifo_full) begin
                    fifo_we   = 1'b1;
                    fifo_din  = seq;
                    cnt_nxt   = '0;
`ifdef FIFO_WR_CSUM_EN
                    csum_nxt  = '0;
`endif
                    state_nxt = DATA;
                end
            end
            DATA: begin
                s_ready = !fifo_full;
                if (s_valid && !fifo_full) begin
                    fifo_we  = 1'b1;
                    fifo_din = s_data;
                    cnt_nxt  = cnt_inc;
`ifdef FIFO_WR_CSUM_EN
                    csum_nxt = csum ^ s_data;
`endif
                    // s_last wins over the length limit, so a full-length packet is not flagged
                    if (s_last) begin
                        state_nxt = TRL;
                    end else if (cnt_inc == CW'(MAX_LEN)) begin
                        state_nxt = TRL;
                        trunc_nxt = 1'b1;
                    end
                end
            end
            TRL: begin
                if (!fifo_full) begin
                    fifo_we  = 1'b1;
                    fifo_din = DW'(cnt);
`ifdef FIFO_WR_CSUM_EN
                    state_nxt = CSUM;
`else
                    seq_nxt   = seq + DW'(1);
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef FIFO_WR_CSUM_EN
            CSUM: begin
                if (!fifo_full) begin
                    fifo_we   = 1'b1;
                    fifo_din  = csum;
                    seq_nxt   = seq + DW'(1);
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

endmodule
